// File: rtl/detector_jogada.sv
// Button-press conditioner for the memory game: debounces the raw one-hot button bus,
// rejects multi-button patterns and demands a full release before accepting another move.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       limpa,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic [2:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CONT_ZERO = CW'(0);
  localparam logic [CW-1:0] CONT_ONE  = CW'(1);
  localparam logic [CW-1:0] CONT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CONT_MAX  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRO       = 3'd1,
    REGISTRA     = 3'd2,
    INVALIDA     = 3'd3,
    ESPERA_SOLTA = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [3:0]    amostra_q, amostra_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          carrega_s;

  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c < CONT_MAX) ? (c + CONT_ONE) : c;
  endfunction

  // State, counter, candidate pattern and move registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= ESPERA_SOLTA;
      cont_q    <= CONT_ZERO;
      amostra_q <= 4'b0000;
      jogada_q  <= 4'b0000;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      amostra_q <= amostra_d;
      jogada_q  <= jogada_d;
    end
  end

  // Next-state logic: filter the press, classify it, then wait for a clean release
  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    amostra_d = amostra_q;
    carrega_s = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (botoes != 4'b0000) begin
          estado_d  = FILTRO;
          amostra_d = botoes;
          cont_d    = CONT_ONE;
        end else begin
          estado_d  = OCIOSO;
        end
      end
      FILTRO: begin
        if (botoes == 4'b0000) begin
          estado_d = OCIOSO;
        end else if (botoes != amostra_q) begin
          // a different pattern restarts the stability count on that pattern
          amostra_d = botoes;
          cont_d    = CONT_ONE;
        end else if (cont_q < CONT_LAST) begin
          cont_d = sat_inc(cont_q);
        end else if (one_hot(amostra_q)) begin
          estado_d  = REGISTRA;
          carrega_s = 1'b1;
        end else begin
          estado_d = INVALIDA;
        end
      end
      REGISTRA: begin
        estado_d = ESPERA_SOLTA;
        cont_d   = CONT_ZERO;
      end
      INVALIDA: begin
        estado_d = ESPERA_SOLTA;
        cont_d   = CONT_ZERO;
      end
      ESPERA_SOLTA: begin
        if (botoes != 4'b0000) begin
          cont_d = CONT_ZERO;
        end else if (cont_q >= CONT_LAST) begin
          estado_d = OCIOSO;
          cont_d   = sat_inc(cont_q);
        end else begin
          cont_d = sat_inc(cont_q);
        end
      end
      default: begin
        estado_d = ESPERA_SOLTA;
        cont_d   = CONT_ZERO;
      end
    endcase
  end

  // Move register: a fresh load takes priority over a clear request
  always_comb begin
    jogada_d = jogada_q;
    if (carrega_s) begin
      jogada_d = amostra_q;
    end else if (limpa) begin
      jogada_d = 4'b0000;
    end else begin
      jogada_d = jogada_q;
    end
  end

  assign jogada          = jogada_q;
  assign tem_jogada      = (estado_q == REGISTRA);
  assign jogada_invalida = (estado_q == INVALIDA);
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: directed scenarios plus random bursts,
// every cycle compared against a run-length reference model of the press/release rules.
module tb_detector_jogada;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'b0000;
  logic       limpa = 1'b0;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic [2:0] db_estado;

  detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .botoes         (botoes),
    .limpa          (limpa),
    .jogada         (jogada),
    .tem_jogada     (tem_jogada),
    .jogada_invalida(jogada_invalida),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int n_inval = 0;

  // Reference model: "armed" means a full release has been seen; run counts identical
  // consecutive non-zero samples; zeros counts consecutive idle samples while waiting.
  bit         m_armed = 1'b0;
  bit         m_busy  = 1'b0;
  int         m_zeros = 0;
  int         m_run   = 0;
  logic [3:0] m_pat   = 4'b0000;
  logic [3:0] m_jog   = 4'b0000;
  bit         m_tem   = 1'b0;
  bit         m_inv   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] b, input bit l, input bit r);
    bit load;
    load = 1'b0;
    if (r) begin
      m_armed = 1'b0; m_busy = 1'b0; m_zeros = 0; m_run = 0;
      m_jog = 4'b0000; m_tem = 1'b0; m_inv = 1'b0;
    end else if (m_busy) begin
      m_busy = 1'b0; m_tem = 1'b0; m_inv = 1'b0; m_zeros = 0;
      if (l) m_jog = 4'b0000;
    end else if (!m_armed) begin
      if (b != 4'b0000) m_zeros = 0;
      else begin
        m_zeros++;
        if (m_zeros >= D) begin m_armed = 1'b1; m_run = 0; end
      end
      if (l) m_jog = 4'b0000;
    end else begin
      if (b == 4'b0000) m_run = 0;
      else if (m_run > 0 && b == m_pat) m_run++;
      else begin m_pat = b; m_run = 1; end
      if (m_run >= D) begin
        m_busy = 1'b1; m_armed = 1'b0; m_run = 0;
        if ($countones(m_pat) == 1) begin m_tem = 1'b1; m_jog = m_pat; load = 1'b1; end
        else m_inv = 1'b1;
      end
      if (l && !load) m_jog = 4'b0000;
    end
  endtask

  function automatic logic [2:0] model_code();
    if (m_busy)      return m_tem ? 3'd2 : 3'd3;
    else if (!m_armed) return 3'd4;
    else if (m_run > 0) return 3'd1;
    else return 3'd0;
  endfunction

  task automatic step(input logic [3:0] b, input bit l, input bit r);
    @(negedge clock);
    botoes = b; limpa = l; reset = r;
    @(posedge clock);
    model_edge(b, l, r);
    #1;
    chk("jogada", jogada, m_jog);
    chk("tem_jogada", tem_jogada, m_tem);
    chk("jogada_invalida", jogada_invalida, m_inv);
    chk("db_estado", db_estado, model_code());
    if (tem_jogada) n_pulse++;
    if (jogada_invalida) n_inval++;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0, 1'b0);
  endtask

  initial begin
    int p0, v0;
    logic [3:0] pat;

    // 1: reset, then release count back to idle
    step(4'b0000, 1'b0, 1'b1);
    chk("rst_db_estado", db_estado, 3'd4);
    chk("rst_jogada", jogada, 4'b0000);
    hold(4'b0000, 4);
    chk("idle_after_rst", db_estado, 3'd0);
    hold(4'b0000, 6);

    // 2: clean single press
    p0 = n_pulse;
    hold(4'b0010, 3);
    chk("press_not_yet", tem_jogada, 1'b0);
    hold(4'b0010, 1);
    chk("pulse_4th_edge", tem_jogada, 1'b1);
    chk("jogada_in_pulse", jogada, 4'b0010);
    hold(4'b0010, 6);
    hold(4'b0000, 10);
    chk("t2_pulses", n_pulse - p0, 1);
    chk("jogada_held", jogada, 4'b0010);

    // 3: short glitch then pattern change
    p0 = n_pulse;
    hold(4'b0100, 2);
    hold(4'b0000, 1);
    chk("glitch_idle", db_estado, 3'd0);
    hold(4'b0001, 2);
    hold(4'b0010, 10);
    hold(4'b0000, 10);
    chk("t3_pulses", n_pulse - p0, 1);

    // 4: two buttons at once
    p0 = n_pulse; v0 = n_inval;
    hold(4'b0011, 10);
    hold(4'b0000, 10);
    chk("t4_invalid", n_inval - v0, 1);
    chk("t4_pulses", n_pulse - p0, 0);
    chk("t4_jogada_kept", jogada, 4'b0010);

    // 5: bounce during release, then a train of presses
    p0 = n_pulse;
    hold(4'b1000, 10);
    hold(4'b0000, 1);
    hold(4'b1000, 1);
    hold(4'b0000, 10);
    chk("t5_bounce_pulses", n_pulse - p0, 1);
    chk("t5_jogada", jogada, 4'b1000);
    p0 = n_pulse;
    for (int i = 0; i < 16; i++) begin
      pat = 4'b0001 << (i % 4);
      hold(pat, 10);
      hold(4'b0000, 10);
    end
    chk("t5_train_pulses", n_pulse - p0, 16);

    // 6: clear, and a button held across reset
    step(4'b0000, 1'b1, 1'b0);
    chk("limpa_clears", jogada, 4'b0000);
    p0 = n_pulse;
    step(4'b0001, 1'b0, 1'b1);
    hold(4'b0001, 10);
    chk("held_rst_pulses", n_pulse - p0, 0);
    hold(4'b0000, 5);
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    chk("after_release_pulses", n_pulse - p0, 1);

    // Random bursts with occasional clears and resets
    for (int k = 0; k < 600; k++) begin
      int sel, len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if (sel < 3) pat = 4'b0000;
      else if (sel < 8) pat = 4'b0001 << $urandom_range(0, 3);
      else pat = 4'($urandom_range(0, 15));
      for (int j = 0; j < len; j++)
        step(pat, ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game datapath/FSM of the memory game.
- Turns the raw one-hot `botoes` bus into a single-cycle `tem_jogada` pulse plus a latched 4-bit `jogada` code, which the datapath compares against memory and writes on new-move insertion.
- Filters contact bounce, rejects multi-button presses, and requires full release before the next move is accepted.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press or a release. Legal range is 2..255.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- botoes  in  4  raw buttons, one-hot when valid (0001, 0010, 0100, 1000)
- limpa  in  1  synchronous clear of the `jogada` register
- jogada  out  4  last accepted one-hot move; held until the next accepted move, `limpa` or `reset`
- tem_jogada  out  1  one-cycle pulse: a valid move was accepted and `jogada` is valid this cycle
- jogada_invalida  out  1  one-cycle pulse: a stable non-one-hot, non-zero pattern was detected
- db_estado  out  3  current FSM state code, for the 7-segment debug display

Behaviour:

General rules
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Input sampling: `botoes` is used directly in next-state logic, with no extra input register.
- Internal registers:
  - `amostra[3:0]`: candidate pattern.
  - `cont`: width $clog2(DEBOUNCE_CYCLES+1). Saturates, never wraps.
- Outputs:
  - `tem_jogada` and `jogada_invalida` are Moore outputs decoded from state.

State codes and reset values
- OCIOSO=0, FILTRO=1, REGISTRA=2, INVALIDA=3, ESPERA_SOLTA=4.
- Reset (any cycle, including mid-press or mid-filter) forces:
  - state=ESPERA_SOLTA, cont=0, amostra=0000, jogada=0000;
  - tem_jogada=0, jogada_invalida=0, db_estado=4.
- This blocks a button held across reset from producing a move.

Transitions (evaluated at each rising edge)
- OCIOSO:
  - botoes==0000 → stay.
  - Otherwise → FILTRO, with amostra<=botoes and cont<=1.
- FILTRO:
  - botoes==0000 → OCIOSO (glitch discarded).
  - botoes!=amostra → stay, with amostra<=botoes and cont<=1 (restart filtering on the new pattern).
  - botoes==amostra and cont<DEBOUNCE_CYCLES-1 → cont<=cont+1.
  - botoes==amostra and cont==DEBOUNCE_CYCLES-1:
    - amostra one-hot → REGISTRA, with jogada<=amostra;
    - otherwise → INVALIDA.
- REGISTRA: tem_jogada=1 for exactly this cycle → ESPERA_SOLTA, with cont<=0.
- INVALIDA: jogada_invalida=1 for exactly this cycle; `jogada` unchanged → ESPERA_SOLTA, with cont<=0.
- ESPERA_SOLTA:
  - botoes!=0000 → cont<=0.
  - Else cont<=cont+1.
  - When cont==DEBOUNCE_CYCLES-1 and botoes==0000 → OCIOSO.

Latency
- Let E0 be the first edge sampling a non-zero pattern that then stays stable.
- Entry to REGISTRA/INVALIDA occurs on edge E(DEBOUNCE_CYCLES-1).
- The pulse is high for the following clock period, so a press must be stable for DEBOUNCE_CYCLES edges.
- `jogada` updates on the same edge that tem_jogada rises, so it is valid in the pulse cycle.
- The minimum gap between two accepted moves is 2*DEBOUNCE_CYCLES+1 cycles.

Boundary conditions
- `limpa`: jogada<=0000 on the next edge. If `limpa` and a load (entry to REGISTRA) coincide, the load wins.
- `limpa` has no effect on the FSM.
- Bounce while in ESPERA_SOLTA restarts the release count and never generates a pulse.
- A held button never produces a second `tem_jogada`.
- At most one of tem_jogada / jogada_invalida is ever high.

Test Plan:
1. Reset with botoes=0000, then hold 10 cycles → db_estado=4 after reset, =0 after 4 more edges. No pulses; jogada=0000.
2. From OCIOSO, drive botoes=0010 at negedge for 10 cycles, then 0000 → exactly one tem_jogada pulse, rising on the 4th sampling edge. jogada=0010 in the pulse cycle and held after release; db_estado sequence 1,2,4,0.
3. botoes=0100 for 2 cycles then 0000 → no pulse, state back to 0. Then 0001 for 2 cycles, 0010 for 10 cycles → single tem_jogada, with jogada=0010.
4. botoes=0011 for 10 cycles → one jogada_invalida pulse, no tem_jogada, jogada keeps previous value 0010.
5. botoes=1000 for 10 cycles, 0000 for 1 cycle, 1000 for 1 cycle, then 0000 for 10 cycles → exactly one tem_jogada (jogada=1000). Repeat with 16 consecutive one-hot presses at 20-cycle spacing → exactly 16 pulses, each with matching jogada.
6. Pulse limpa for 1 cycle → jogada=0000 next edge. Assert reset while botoes=0001 is held, keep 0001 for 10 more cycles → no tem_jogada. After release (≥4 cycles) and a new 0001 press → one pulse.
